// File: rtl/ddr5_bank_cmd_sequencer.sv
// Closed-page DDR5 command sequencer for a single bank request.
// Issues ACT0/ACT1, RD0/RD1 or WR0/WR1, then PRE, with tRCD, tRAS, tRTP,
// write recovery and tRP spacing measured in controller clock cycles.
// All outputs are registered from the next-state decode.
module ddr5_bank_cmd_sequencer #(
    parameter int unsigned TRCD   = 39,
    parameter int unsigned TRAS   = 76,
    parameter int unsigned TRTP   = 18,
    parameter int unsigned TCWL   = 38,
    parameter int unsigned TBURST = 8,
    parameter int unsigned TWR    = 72,
    parameter int unsigned TRP    = 39,
    parameter int unsigned CNT_W  = 9
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_bg,
    input  logic [1:0]  req_bank,
    input  logic [15:0] req_row,
    input  logic [9:0]  req_col,
    output logic        cmd_valid,
    output logic [2:0]  cmd,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_addr,
    output logic        req_done,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
    } state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  bg;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } req_t;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_ACT0 = 3'd1;
    localparam logic [2:0] C_ACT1 = 3'd2;
    localparam logic [2:0] C_RD0  = 3'd3;
    localparam logic [2:0] C_RD1  = 3'd4;
    localparam logic [2:0] C_WR0  = 3'd5;
    localparam logic [2:0] C_WR1  = 3'd6;
    localparam logic [2:0] C_PRE  = 3'd7;

    // PRE thresholds relative to ACT0, in timer-width arithmetic
    localparam logic [CNT_W-1:0] TRAS_C = CNT_W'(TRAS);
    localparam logic [CNT_W-1:0] RD_SUM = CNT_W'(TRCD) + CNT_W'(TRTP);
    localparam logic [CNT_W-1:0] WR_SUM = CNT_W'(TRCD) + CNT_W'(TCWL) + CNT_W'(TBURST) + CNT_W'(TWR);
    localparam logic [CNT_W-1:0] RD_THR = (TRAS_C > RD_SUM) ? TRAS_C : RD_SUM;
    localparam logic [CNT_W-1:0] WR_THR = (TRAS_C > WR_SUM) ? TRAS_C : WR_SUM;
    localparam logic [CNT_W:0]   TRCD_C = (CNT_W+1)'(TRCD);
    localparam logic [CNT_W:0]   TRP_C  = (CNT_W+1)'(TRP);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, nxt;
    req_t             rq, incoming, src;
    logic [CNT_W-1:0] cnt, pre_thr;
    logic [CNT_W:0]   cnt1;
    logic             accept;
    logic [2:0]       n_cmd;
    logic [15:0]      n_addr;

    // req_ready is a register, so acceptance has no path back to it
    assign accept   = req_valid && req_ready;
    assign incoming = '{write: req_write, bg: req_bg, bank: req_bank, row: req_row, col: req_col};
    // value the timer will hold next cycle, one bit wider so compares never wrap
    assign cnt1     = {1'b0, cnt} + (CNT_W+1)'(1);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= nxt;
    end

    // Next-state and next-output decode
    always_comb begin
        nxt    = state;
        src    = accept ? incoming : rq;
        n_cmd  = C_NOP;
        n_addr = '0;
        case (state)
            S_IDLE:                 if (accept) nxt = S_ACT0;
            S_ACT0:                 nxt = S_ACT1;
            S_ACT1, S_WAIT_RCD:     nxt = (cnt1 >= TRCD_C) ? S_CAS0 : S_WAIT_RCD;
            S_CAS0:                 nxt = S_CAS1;
            S_CAS1, S_WAIT_PRE:     nxt = (cnt1 >= {1'b0, pre_thr}) ? S_PRE : S_WAIT_PRE;
            S_PRE, S_WAIT_RP:       nxt = (cnt1 >= TRP_C) ? S_IDLE : S_WAIT_RP;
            default:                nxt = S_IDLE;
        endcase
        case (nxt)
            S_ACT0: begin n_cmd = C_ACT0; n_addr = src.row; end
            S_ACT1: begin n_cmd = C_ACT1; n_addr = src.row; end
            S_CAS0: begin n_cmd = src.write ? C_WR0 : C_RD0; n_addr = {6'b0, src.col}; end
            S_CAS1: begin n_cmd = src.write ? C_WR1 : C_RD1; n_addr = {6'b0, src.col}; end
            S_PRE:  n_cmd = C_PRE;
            default: ;
        endcase
    end

    // Single timer: zero at ACT0 for the bank timings, re-zeroed at PRE for tRP
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                         cnt <= '0;
        else if (nxt == S_ACT0 || nxt == S_PRE) cnt <= '0;
        else if (cnt != CNT_MAX)              cnt <= cnt + CNT_W'(1);
    end

    // Capture the request and its PRE threshold on acceptance
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rq      <= '0;
            pre_thr <= '0;
        end else if (accept) begin
            rq      <= incoming;
            pre_thr <= req_write ? WR_THR : RD_THR;
        end
    end

    // Registered command-side outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid <= 1'b0;
            cmd       <= C_NOP;
            cmd_addr  <= '0;
            cmd_bg    <= '0;
            cmd_bank  <= '0;
            req_done  <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            cmd_valid <= (n_cmd != C_NOP);
            cmd       <= n_cmd;
            cmd_addr  <= n_addr;
            if (accept) begin
                cmd_bg   <= req_bg;
                cmd_bank <= req_bank;
            end
            req_done  <= (nxt == S_PRE);
            busy      <= (nxt != S_IDLE);
            req_ready <= (nxt == S_IDLE);
        end
    end

endmodule

// File: tb/tb_ddr5_bank_cmd_sequencer.sv
// Directed bench for ddr5_bank_cmd_sequencer: four instances with different
// timing parameters share one request bus, each with its own valid enable.
// Outputs are logged per cycle on the falling edge and checked afterwards.
module tb_ddr5_bank_cmd_sequencer;

    localparam int TRCD = 39;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_write = 1'b0;
    logic [2:0] req_bg = '0;
    logic [1:0] req_bank = '0;
    logic [15:0] req_row = '0;
    logic [9:0] req_col = '0;
    logic [3:0] en = '0;

    logic [3:0] o_rdy, o_vld, o_done, o_busy;
    logic [3:0][2:0] o_cmd, o_bg;
    logic [3:0][1:0] o_bank;
    logic [3:0][15:0] o_addr;

    always #5 clock = ~clock;

    // d0 default, d1 TRTP=60, d2 TRAS=57 (tie with TRCD+TRTP), d3 TRP=1
    for (genvar g = 0; g < 4; g++) begin : g_dut
        ddr5_bank_cmd_sequencer #(
            .TRAS(g == 2 ? 57 : 76),
            .TRTP(g == 1 ? 60 : 18),
            .TRP (g == 3 ? 1 : 39)
        ) u_dut (
            .clock(clock), .reset_n(reset_n),
            .req_valid(req_valid && en[g]), .req_ready(o_rdy[g]),
            .req_write(req_write), .req_bg(req_bg), .req_bank(req_bank),
            .req_row(req_row), .req_col(req_col),
            .cmd_valid(o_vld[g]), .cmd(o_cmd[g]), .cmd_bg(o_bg[g]), .cmd_bank(o_bank[g]),
            .cmd_addr(o_addr[g]), .req_done(o_done[g]), .busy(o_busy[g])
        );
    end

    typedef struct packed {
        logic        vld;
        logic [2:0]  cmd;
        logic [2:0]  bg;
        logic [1:0]  bank;
        logic [15:0] addr;
        logic        done;
        logic        busy;
        logic        rdy;
    } obs_t;

    typedef struct {
        int          t;
        int          d;
        int          off;
        logic [2:0]  cmd;
        logic [15:0] addr;
        logic        done;
        logic        rdy;
    } vec_t;

    obs_t lg [4][4096];
    logic hs [4][4096];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int acc [2];
    vec_t vt [18];

    // Hand-computed ACT0-to-PRE offsets per instance, and tRP
    int pre_rd [4] = '{76, 99, 57, 76};
    int trp_a  [4] = '{39, 39, 39, 1};

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (cyc < 4096) begin
                lg[i][cyc] <= {o_vld[i], o_cmd[i], o_bg[i], o_bank[i], o_addr[i], o_done[i], o_busy[i], o_rdy[i]};
                hs[i][cyc] <= req_valid && en[i] && o_rdy[i];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] e, input logic wr, input logic [2:0] bg, input logic [1:0] bank,
                         input logic [15:0] row, input logic [9:0] col, output int a);
        int n;
        en = e; req_write = wr; req_bg = bg; req_bank = bank; req_row = row; req_col = col;
        n = 0;
        while ((o_rdy & e) != e && n < 300) begin tick(1); n++; end
        if (n >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL issue_ready: got %b expected %b", o_rdy & e, e);
        end
        req_valid = 1'b1;
        a = cyc;
        tick(1);
        req_valid = 1'b0;
    endtask

    // Full cycle-by-cycle expectation of one sequence accepted at cycle a
    task automatic chk_seq(input int i, input int a, input int pre, input int trp, input logic wr,
                           input logic [15:0] row, input logic [9:0] col, input logic [2:0] bg,
                           input logic [1:0] bank, input string nm);
        obs_t e;
        for (int k = 0; k <= pre + trp; k++) begin
            e = '0;
            e.bg = bg; e.bank = bank;
            e.busy = (k < pre + trp);
            e.rdy  = (k == pre + trp);
            if (k == 0 || k == 1) begin
                e.vld = 1'b1; e.cmd = (k == 0) ? 3'd1 : 3'd2; e.addr = row;
            end else if (k == TRCD || k == TRCD + 1) begin
                e.vld = 1'b1; e.addr = {6'b0, col};
                e.cmd = wr ? ((k == TRCD) ? 3'd5 : 3'd6) : ((k == TRCD) ? 3'd3 : 3'd4);
            end else if (k == pre) begin
                e.vld = 1'b1; e.cmd = 3'd7; e.done = 1'b1;
            end
            chk($sformatf("%s d%0d T+%0d", nm, i, k), 64'(lg[i][a + 1 + k]), 64'(e));
        end
    endtask

    task automatic b2b(input int i);
        int a1, a2, n, cnt, p;
        a1 = -1; a2 = -1;
        en = 4'b0001 << i;
        req_write = 1'b0; req_bg = 3'd1; req_bank = 2'd2; req_row = 16'h1111; req_col = 10'h011;
        req_valid = 1'b1;
        for (n = 0; n < 20; n++) begin
            if (o_rdy[i]) begin a1 = cyc; tick(1); break; end
            tick(1);
        end
        req_bg = 3'd5; req_bank = 2'd3; req_row = 16'h2222; req_col = 10'h022;
        for (n = 0; n < 300; n++) begin
            if (o_rdy[i]) begin a2 = cyc; tick(1); break; end
            tick(1);
        end
        req_valid = 1'b0;
        if (a1 < 0 || a2 < 0) begin
            n_chk++; n_fail++;
            $display("FAIL b2b_timeout d%0d: got a1=%0d a2=%0d expected both accepted", i, a1, a2);
            return;
        end
        p = a1 + 1 + pre_rd[i];
        tick(pre_rd[i] + trp_a[i] + 5);
        // second ACT0 (a2+1) follows the first PRE by TRP+1
        chk($sformatf("b2b_act0_gap d%0d", i), 64'(a2 + 1 - p), 64'(trp_a[i] + 1));
        cnt = 0;
        for (int c = a1; c <= a2 + pre_rd[i] + trp_a[i] + 2; c++) if (hs[i][c]) cnt++;
        chk($sformatf("b2b_handshakes d%0d", i), 64'(cnt), 64'd2);
        chk_seq(i, a1, pre_rd[i], trp_a[i], 1'b0, 16'h1111, 10'h011, 3'd1, 2'd2, "b2b_first");
        chk_seq(i, a2, pre_rd[i], trp_a[i], 1'b0, 16'h2222, 10'h022, 3'd5, 2'd3, "b2b_second");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, rel, cnt;
        // {test, dut, offset from acceptance, cmd, addr, req_done, req_ready}
        vt[0]  = '{0, 0, 1,   3'd1, 16'h1A2B, 1'b0, 1'b0};
        vt[1]  = '{0, 0, 2,   3'd2, 16'h1A2B, 1'b0, 1'b0};
        vt[2]  = '{0, 0, 40,  3'd3, 16'h03C4, 1'b0, 1'b0};
        vt[3]  = '{0, 0, 41,  3'd4, 16'h03C4, 1'b0, 1'b0};
        vt[4]  = '{0, 0, 77,  3'd7, 16'h0000, 1'b1, 1'b0};
        vt[5]  = '{0, 0, 115, 3'd0, 16'h0000, 1'b0, 1'b0};
        vt[6]  = '{0, 0, 116, 3'd0, 16'h0000, 1'b0, 1'b1};
        vt[7]  = '{0, 1, 100, 3'd7, 16'h0000, 1'b1, 1'b0};
        vt[8]  = '{0, 1, 77,  3'd0, 16'h0000, 1'b0, 1'b0};
        vt[9]  = '{0, 2, 58,  3'd7, 16'h0000, 1'b1, 1'b0};
        vt[10] = '{0, 3, 78,  3'd0, 16'h0000, 1'b0, 1'b1};
        vt[11] = '{1, 0, 40,  3'd5, 16'h03C4, 1'b0, 1'b0};
        vt[12] = '{1, 0, 41,  3'd6, 16'h03C4, 1'b0, 1'b0};
        vt[13] = '{1, 0, 157, 3'd0, 16'h0000, 1'b0, 1'b0};
        vt[14] = '{1, 0, 158, 3'd7, 16'h0000, 1'b1, 1'b0};
        vt[15] = '{1, 0, 197, 3'd0, 16'h0000, 1'b0, 1'b1};
        vt[16] = '{1, 3, 158, 3'd7, 16'h0000, 1'b1, 1'b0};
        vt[17] = '{1, 3, 159, 3'd0, 16'h0000, 1'b0, 1'b1};

        // Reset state
        #12;
        for (int i = 0; i < 4; i++)
            chk($sformatf("reset_outputs d%0d", i),
                64'({o_vld[i], o_cmd[i], o_bg[i], o_bank[i], o_addr[i], o_done[i], o_busy[i], o_rdy[i]}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("ready_after_reset d%0d", i), 64'({o_rdy[i], o_busy[i]}), 64'b10);

        // Single read on all instances
        tick(5);
        issue(4'b1111, 1'b0, 3'd2, 2'd1, 16'h1A2B, 10'h3C4, acc[0]);
        tick(150);
        // Single write on all instances
        issue(4'b1111, 1'b1, 3'd2, 2'd1, 16'h1A2B, 10'h3C4, acc[1]);
        tick(210);

        for (int v = 0; v < 18; v++) begin
            obs_t o;
            o = lg[vt[v].d][acc[vt[v].t] + vt[v].off];
            chk($sformatf("vec%0d t%0d d%0d +%0d", v, vt[v].t, vt[v].d, vt[v].off),
                64'({o.vld, o.cmd, o.addr, o.done, o.rdy}),
                64'({vt[v].cmd != 3'd0, vt[v].cmd, vt[v].addr, vt[v].done, vt[v].rdy}));
        end
        for (int i = 0; i < 4; i++) begin
            chk_seq(i, acc[0], pre_rd[i], trp_a[i], 1'b0, 16'h1A2B, 10'h3C4, 3'd2, 2'd1, "read_seq");
            chk_seq(i, acc[1], 157, trp_a[i], 1'b1, 16'h1A2B, 10'h3C4, 3'd2, 2'd1, "write_seq");
        end

        // Back-to-back with req_valid held high
        b2b(0);
        b2b(3);

        // Reset in the middle of a read, during the tRCD wait
        issue(4'b0001, 1'b0, 3'd6, 2'd3, 16'hBEEF, 10'h155, a);
        while (cyc < a + 1 + 20) tick(1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_async",
            64'({o_vld[0], o_cmd[0], o_bg[0], o_bank[0], o_addr[0], o_done[0], o_busy[0], o_rdy[0]}), 64'd0);
        tick(2);
        @(negedge clock);
        reset_n = 1'b1;
        rel = cyc;
        tick(1);
        chk("midreset_ready_after_release", 64'({o_rdy[0], o_busy[0]}), 64'b10);
        tick(130);
        cnt = 0;
        for (int c = rel; c < rel + 129; c++) if (lg[0][c].vld || lg[0][c].done) cnt++;
        chk("midreset_no_cmds", 64'(cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
